relu_maxpool_buf: RTL

- Downstream consumer of the serial MAC/ReLU stage.
- Takes the ReLU output stream one word per valid strobe and max-pools non-overlapping windows of P consecutive words.
- Buffers the pooled results in a small FIFO.
- Hands results to the next layer/readout over a ready/valid interface. A layer-boundary flag flushes any partial window.

---
 rtl/relu_maxpool_buf_pkg.sv | 25 ++
 rtl/relu_maxpool_buf_pool_fifo.sv | 52 +++++
 rtl/relu_maxpool_buf.sv | 68 ++++++
 3 files changed

// File: rtl/relu_maxpool_buf_pkg.sv
// Shared constants and types for the ReLU -> max-pool stage.
// The data width here must match the MAC/ReLU stage output width.
package relu_maxpool_buf_pkg;

    localparam int MAC_W = 8;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic             last;
        logic [MAC_W-1:0] data;
    } pool_entry_t;

endpackage

// File: rtl/relu_maxpool_buf_pool_fifo.sv
// Small register FIFO for pooled results; head is read straight from storage.
// Write while full is accepted only when a read frees a slot in the same cycle.
module pool_fifo
    import relu_maxpool_buf_pkg::*;
#(
    parameter int W  = MAC_W + 1,
    parameter int D  = 4,
    localparam int AW = clog2(D),
    localparam int CW = clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(D));
    assign empty   = (count == '0);
    assign push    = wr_en && (!full || rd_en);
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rptr];

    // Storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/relu_maxpool_buf.sv
// Max-pools non-overlapping windows of P ReLU words and buffers results in a FIFO.
// in_last closes the current window early so no partial window crosses a layer.
module relu_maxpool_buf
    import relu_maxpool_buf_pkg::*;
#(
    parameter int W = MAC_W,
    parameter int P = 2,
    parameter int D = 4,
    localparam int CW = clog2(D + 1),
    localparam int KW = (P > 1) ? clog2(P) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [KW-1:0] k;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic          close;
    logic          full;
    logic          empty;

    // First word of a window seeds the max; ties keep acc.
    always_comb begin
        acc_next = in_data;
        if (k != '0 && $signed(acc) >= $signed(in_data)) acc_next = acc;
    end

    assign close = in_valid && (in_last || k == KW'(P - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k        <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                acc <= acc_next;
                k   <= close ? '0 : k + KW'(1);
            end
            if (close && full && !out_ready) overflow <= 1'b1;
        end
    end

    pool_fifo #(.W(W + 1), .D(D)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (close),
        .wr_data ({in_last, acc_next}),
        .rd_en   (out_ready),
        .rd_data ({out_last, out_data}),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = !empty;

endmodule
